// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, control-bundle bit layout and bubble constant.
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC = 5;
    localparam int CTRL_REGDST = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;
    typedef logic [CTRL_W-1:0] ctrl_t;
    localparam ctrl_t BUBBLE = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import pipe_pkg::*;
    logic [4:0] IFIDRs, IFIDRt, IFIDRd;
    logic IFIDUsesRt;
    ctrl_t IFIDCtrl;
    logic [DATA_W-1:0] ReadData1, ReadData2, SignExt, IFIDPC;
    logic Flush;
    logic [4:0] IDEXRs, IDEXRt, IDEXRd;
    ctrl_t IDEXCtrl;
    logic [DATA_W-1:0] IDEXA, IDEXB, IDEXImm, IDEXPC;
    logic PCWrite, IFIDWrite;
    logic [31:0] StallCount, FlushCount;
    modport master(
        output IFIDRs, IFIDRt, IFIDRd, IFIDUsesRt, IFIDCtrl, ReadData1, ReadData2, SignExt, IFIDPC, Flush,
        input IDEXRs, IDEXRt, IDEXRd, IDEXCtrl, IDEXA, IDEXB, IDEXImm, IDEXPC, PCWrite, IFIDWrite,
        StallCount, FlushCount
    );
    modport slave(
        input IFIDRs, IFIDRt, IFIDRd, IFIDUsesRt, IFIDCtrl, ReadData1, ReadData2, SignExt, IFIDPC, Flush,
        output IDEXRs, IDEXRt, IDEXRd, IDEXCtrl, IDEXA, IDEXB, IDEXImm, IDEXPC, PCWrite, IFIDWrite,
        StallCount, FlushCount
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the register a load in EX is still fetching.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_hazard
);
    assign o_hazard = i_ex_memread && (i_ex_rt != REG_ZERO) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and branch-flush bubbles.
// Optional perf counters enabled by defining IDEX_PERF_EN.
module id_ex_stage
    import pipe_pkg::*;
(
    input logic Clk,
    input logic Rst,
    id_ex_stage_if.slave bus
);
    logic w_hazard, w_stall, w_bubble;
    logic [4:0] r_rs, r_rt, r_rd;
    ctrl_t r_ctrl;
    logic [DATA_W-1:0] r_a, r_b, r_imm, r_pc;

    load_use_detect u_detect (
        .i_ex_memread(r_ctrl[CTRL_MEMREAD]),
        .i_ex_rt(r_rt),
        .i_id_rs(bus.IFIDRs),
        .i_id_rt(bus.IFIDRt),
        .i_id_uses_rt(bus.IFIDUsesRt),
        .o_hazard(w_hazard)
    );

    assign w_stall = w_hazard && !bus.Flush;
    // Flush and stall both squash everything, so one zeroing path covers reset too.
    assign w_bubble = Rst || bus.Flush || w_hazard;
    assign bus.PCWrite = Rst || !w_stall;
    assign bus.IFIDWrite = Rst || !w_stall;

    always_ff @(posedge Clk) begin
        if (w_bubble) begin
            r_ctrl <= BUBBLE;
            r_rs <= REG_ZERO;
            r_rt <= REG_ZERO;
            r_rd <= REG_ZERO;
            r_a <= '0;
            r_b <= '0;
            r_imm <= '0;
            r_pc <= '0;
        end else begin
            r_ctrl <= bus.IFIDCtrl;
            r_rs <= bus.IFIDRs;
            r_rt <= bus.IFIDRt;
            r_rd <= bus.IFIDRd;
            r_a <= bus.ReadData1;
            r_b <= bus.ReadData2;
            r_imm <= bus.SignExt;
            r_pc <= bus.IFIDPC;
        end
    end

    assign bus.IDEXCtrl = r_ctrl;
    assign bus.IDEXRs = r_rs;
    assign bus.IDEXRt = r_rt;
    assign bus.IDEXRd = r_rd;
    assign bus.IDEXA = r_a;
    assign bus.IDEXB = r_b;
    assign bus.IDEXImm = r_imm;
    assign bus.IDEXPC = r_pc;

`ifdef IDEX_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;
    always_ff @(posedge Clk) begin
        r_stall_cnt <= Rst ? '0 : r_stall_cnt + {31'd0, w_stall && !(&r_stall_cnt)};
        r_flush_cnt <= Rst ? '0 : r_flush_cnt + {31'd0, bus.Flush && !(&r_flush_cnt)};
    end
    assign bus.StallCount = r_stall_cnt;
    assign bus.FlushCount = r_flush_cnt;
`else
    assign bus.StallCount = '0;
    assign bus.FlushCount = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed + random steps; expected ID/EX contents queued at drive time, popped after the edge.
module tb_id_ex_stage;
    import pipe_pkg::*;

    typedef struct {
        logic [9:0] ctrl;
        logic [4:0] rs, rt, rd;
        logic [31:0] a, b, imm, pc, sc, fc;
    } exp_t;

    localparam logic [9:0] C_LW  = 10'h360;
    localparam logic [9:0] C_ADD = 10'h212;
    localparam logic [9:0] C_SW  = 10'h0A0;

    logic clk = 0;
    logic rst;
    int passed = 0;
    int total = 0;
    exp_t q[$];
    exp_t m;

    id_ex_stage_if bus();
    id_ex_stage dut(.Clk(clk), .Rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic f, input logic u, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [9:0] ctrl,
                        input logic [31:0] a);
        logic hz;
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst = r;
        bus.Flush = f;
        bus.IFIDUsesRt = u;
        bus.IFIDRs = rs;
        bus.IFIDRt = rt;
        bus.IFIDRd = rd;
        bus.IFIDCtrl = ctrl;
        bus.ReadData1 = a;
        bus.ReadData2 = a ^ 32'hFFFF_0000;
        bus.SignExt = a + 32'd7;
        bus.IFIDPC = {a[29:0], 2'b00};
        hz = m.ctrl[CTRL_MEMREAD] && m.rt != 0 && (m.rt == rs || (u && m.rt == rt));
        #1;
        chk("pcwrite", 32'(bus.PCWrite), 32'(r || !(hz && !f)));
        chk("ifidwrite", 32'(bus.IFIDWrite), 32'(r || !(hz && !f)));
        e = '{ctrl: 10'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, a: 0, b: 0, imm: 0, pc: 0, sc: 0, fc: 0};
        if (!(r || f || hz)) begin
            e.ctrl = ctrl; e.rs = rs; e.rt = rt; e.rd = rd;
            e.a = bus.ReadData1; e.b = bus.ReadData2; e.imm = bus.SignExt; e.pc = bus.IFIDPC;
        end
`ifdef IDEX_PERF_EN
        e.sc = r ? 0 : m.sc + 32'(hz && !f);
        e.fc = r ? 0 : m.fc + 32'(f);
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
        o = q.pop_front();
        chk("ctrl", 32'(bus.IDEXCtrl), 32'(o.ctrl));
        chk("rs", 32'(bus.IDEXRs), 32'(o.rs));
        chk("rt", 32'(bus.IDEXRt), 32'(o.rt));
        chk("rd", 32'(bus.IDEXRd), 32'(o.rd));
        chk("a", bus.IDEXA, o.a);
        chk("b", bus.IDEXB, o.b);
        chk("imm", bus.IDEXImm, o.imm);
        chk("pc", bus.IDEXPC, o.pc);
        chk("stallcnt", bus.StallCount, o.sc);
        chk("flushcnt", bus.FlushCount, o.fc);
        m = o;
    endtask

    initial begin
        m = '{ctrl: 10'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, a: 0, b: 0, imm: 0, pc: 0, sc: 0, fc: 0};
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2, 3, C_ADD, 32'h9);
        step(0, 0, 0, 0, 0, 0, 0, 32'h5);
        // load-use on rs, one-cycle stall, then consumer enters
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h100);
        step(0, 0, 1, 3, 4, 5, C_ADD, 32'h11);
        step(0, 0, 1, 3, 4, 5, C_ADD, 32'h11);
        // store rt dependency, with and without UsesRt
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h104);
        step(0, 0, 1, 2, 3, 0, C_SW, 32'h22);
        step(0, 0, 1, 2, 3, 0, C_SW, 32'h22);
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h108);
        step(0, 0, 0, 2, 3, 6, C_ADD, 32'h33);
        // $0 never stalls
        step(0, 0, 0, 1, 0, 0, C_LW, 32'h10C);
        step(0, 0, 1, 0, 0, 7, C_ADD, 32'h44);
        // back-to-back dependent loads
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h110);
        step(0, 0, 0, 3, 4, 0, C_LW, 32'h114);
        step(0, 0, 0, 3, 4, 0, C_LW, 32'h114);
        step(0, 0, 1, 4, 8, 9, C_ADD, 32'h55);
        step(0, 0, 1, 4, 8, 9, C_ADD, 32'h55);
        // hazard coinciding with flush
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h118);
        step(0, 1, 1, 3, 4, 5, C_ADD, 32'h66);
        // reset while hazard is active
        step(0, 0, 0, 1, 3, 0, C_LW, 32'h11C);
        step(1, 0, 1, 3, 4, 5, C_ADD, 32'h77);
        step(0, 0, 1, 3, 4, 5, C_ADD, 32'h77);
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                 ($urandom_range(0, 1) == 1) ? C_LW : 10'($urandom), $urandom);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
